// File: rtl/mux_scan_nx1.sv
// N-to-1 registered multiplexer with manual channel select and a masked
// automatic scan that dwells DWELL cycles per enabled channel.
module mux_scan_nx1 #(
   parameter int N     = 8,
   parameter int W     = 1,
   parameter int DWELL = 4,
   localparam int SW   = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] din,
   input  logic [SW-1:0]  sel,
   input  logic           en,
   input  logic           mode,
   input  logic [N-1:0]   ch_mask,
   output logic [W-1:0]   dout,
   output logic [SW-1:0]  ch_out,
   output logic           valid,
   output logic           wrap,
   output logic [1:0]     state_dbg
);

   localparam int CW = $clog2(DWELL + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   dwell_cnt;
   logic [SW-1:0]   lowest_ch;
   logic [SW-1:0]   next_ch;
   logic [SW-1:0]   probe_ch;
   logic            scan_live;
   logic            dwell_done;

   assign state_dbg  = state;
   // A sweep is in progress only if the previous cycle already presented a scan sample.
   assign scan_live  = (state == SCAN) && valid;
   assign dwell_done = (dwell_cnt == CW'(DWELL - 1));

   // Lowest set mask bit, and the next set bit after ch_out in circular order.
   // If ch_out is the only set bit the search lands back on ch_out itself.
   always_comb begin
      lowest_ch = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (ch_mask[i]) lowest_ch = SW'(i);
      end
      next_ch  = ch_out;
      probe_ch = '0;
      for (int k = N; k >= 1; k--) begin
         probe_ch = ch_out + SW'(k);
         if (ch_mask[probe_ch]) next_ch = probe_ch;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dout      <= '0;
         ch_out    <= '0;
         valid     <= 1'b0;
         wrap      <= 1'b0;
         dwell_cnt <= '0;
      end else if (!en) begin
         state     <= IDLE;
         valid     <= 1'b0;
         wrap      <= 1'b0;
         dwell_cnt <= '0;
      end else if (!mode) begin
         state     <= MANUAL;
         dout      <= din[int'(sel)*W +: W];
         ch_out    <= sel;
         valid     <= 1'b1;
         wrap      <= 1'b0;
         dwell_cnt <= '0;
      end else begin
         state <= SCAN;
         wrap  <= 1'b0;
         if (ch_mask == '0) begin
            valid     <= 1'b0;
            dwell_cnt <= '0;
         end else if (!scan_live) begin
            dout      <= din[int'(lowest_ch)*W +: W];
            ch_out    <= lowest_ch;
            valid     <= 1'b1;
            dwell_cnt <= '0;
         end else if (!ch_mask[ch_out] || dwell_done) begin
            dout      <= din[int'(next_ch)*W +: W];
            ch_out    <= next_ch;
            valid     <= 1'b1;
            wrap      <= (next_ch <= ch_out);
            dwell_cnt <= '0;
         end else begin
            dout      <= din[int'(ch_out)*W +: W];
            valid     <= 1'b1;
            dwell_cnt <= dwell_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1 (N=8, W=4, DWELL=4): directed scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_mux_scan_nx1;

   localparam int N     = 8;
   localparam int W     = 4;
   localparam int DWELL = 4;
   localparam int SW    = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*W-1:0] din = '0;
   logic [SW-1:0]  sel = '0;
   logic           en = 1'b0;
   logic           mode = 1'b0;
   logic [N-1:0]   ch_mask = '0;
   logic [W-1:0]   dout;
   logic [SW-1:0]  ch_out;
   logic           valid;
   logic           wrap;
   logic [1:0]     state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: age = cycles already spent on the current scan channel
   int m_dout = 0, m_ch = 0, m_valid = 0, m_wrap = 0, m_state = 0, m_age = 0;

   mux_scan_nx1 #(.N(N), .W(W), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .en(en), .mode(mode),
      .ch_mask(ch_mask), .dout(dout), .ch_out(ch_out), .valid(valid),
      .wrap(wrap), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic int chan(input int c);
      return (din >> (c * W)) & ((1 << W) - 1);
   endfunction

   function automatic int lowest(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic int after(input int c, input logic [N-1:0] m);
      for (int k = 1; k <= N; k++) if (m[(c + k) % N]) return (c + k) % N;
      return c;
   endfunction

   task automatic model_step();
      int n;
      if (rst) begin
         m_dout = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_state = 0; m_age = 0;
      end else if (!en) begin
         m_valid = 0; m_wrap = 0; m_state = 0; m_age = 0;
      end else if (!mode) begin
         m_dout = chan(sel); m_ch = sel; m_valid = 1; m_wrap = 0; m_state = 1; m_age = 0;
      end else begin
         m_wrap = 0;
         if (ch_mask == 0) begin
            m_valid = 0; m_age = 0;
         end else if (m_state != 2 || m_valid == 0) begin
            m_ch = lowest(ch_mask); m_age = 1; m_valid = 1;
         end else if (!ch_mask[m_ch] || m_age >= DWELL) begin
            n = after(m_ch, ch_mask);
            m_wrap = (n <= m_ch) ? 1 : 0;
            m_ch = n; m_age = 1;
         end else begin
            m_age = m_age + 1;
         end
         if (ch_mask != 0) m_dout = chan(m_ch);
         m_state = 2;
      end
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("dout", int'(dout), m_dout);
      check("ch_out", int'(ch_out), m_ch);
      check("valid", int'(valid), m_valid);
      check("wrap", int'(wrap), m_wrap);
      check("state", int'(state_dbg), m_state);
   endtask

   initial begin
      int seq[4];
      seq = '{0, 2, 5, 7};

      // reset
      rst = 1'b1; en = 1'b1; mode = 1'b1; ch_mask = 8'hFF;
      for (int i = 0; i < N; i++) din[i*W +: W] = W'(i + 3);
      tick(); tick();
      check("rst_zero", int'({dout, ch_out, valid, wrap}), 0);
      rst = 1'b0;

      // manual stepping
      mode = 1'b0;
      for (int i = 0; i < N; i++) begin
         sel = SW'(i);
         tick();
         check("man_dout", int'(dout), i + 3);
         check("man_ch", int'(ch_out), i);
         check("man_valid", int'(valid), 1);
      end

      // scan sweep over mask A5 (no gap from manual)
      mode = 1'b1; ch_mask = 8'hA5;
      for (int t = 0; t < 20; t++) begin
         tick();
         check("scan_seq", int'(ch_out), seq[(t / DWELL) % 4]);
         check("scan_wrap", int'(wrap), (t > 0 && t % 16 == 0) ? 1 : 0);
      end

      // single enabled channel
      en = 1'b0; tick(); en = 1'b1; ch_mask = 8'h10;
      for (int t = 0; t < 13; t++) begin
         tick();
         check("single_ch", int'(ch_out), 4);
         check("single_wrap", int'(wrap), (t > 0 && t % DWELL == 0) ? 1 : 0);
      end

      // current channel cleared mid-dwell
      en = 1'b0; tick(); en = 1'b1; ch_mask = 8'hA5;
      for (int t = 0; t < 6; t++) tick();
      check("pre_clear_ch", int'(ch_out), 2);
      ch_mask = 8'hA1; tick();
      check("clear_adv", int'(ch_out), 5);

      // empty mask, then resume
      ch_mask = 8'h00; tick();
      check("empty_valid", int'(valid), 0);
      ch_mask = 8'h40; tick();
      check("resume_ch", int'(ch_out), 6);
      check("resume_valid", int'(valid), 1);

      // manual -> scan -> manual
      mode = 1'b0; sel = 3'd1; tick();
      mode = 1'b1; tick();
      mode = 1'b0; sel = 3'd7; tick();
      check("switch_valid", int'(valid), 1);

      // reset mid-scan
      mode = 1'b1; ch_mask = 8'h28;
      for (int t = 0; t < 6; t++) tick();
      rst = 1'b1; tick();
      check("midrst_zero", int'({dout, ch_out, valid, wrap}), 0);
      rst = 1'b0; tick();
      check("post_rst_ch", int'(ch_out), 3);

      // random traffic
      for (int t = 0; t < 400; t++) begin
         din = {$urandom, $urandom};
         sel = SW'($urandom_range(0, N - 1));
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 9) == 0) ch_mask = N'($urandom);
         if ($urandom_range(0, 30) == 0) ch_mask = '0;
         en  = ($urandom_range(0, 19) != 0);
         rst = ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_scan_nx1.md
MUX_SCAN_NX1 -- requirements
Module: mux_scan_nx1

Interface
REQ-001 Parameter N, default 8, number of input channels; SHALL be a power of two, minimum 2.
REQ-002 Parameter W, default 1, data width per channel in bits, minimum 1.
REQ-003 Parameter DWELL, default 4, cycles spent on each channel in scan mode, minimum 1.
REQ-004 Localparam SW = $clog2(N), the channel-index width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 din  input  N*W  flat data bus; channel i occupies bits [i*W +: W].
REQ-008 sel  input  SW  channel index used in manual mode.
REQ-009 en  input  1  block enable; 0 forces the IDLE state.
REQ-010 mode  input  1  0 = manual select, 1 = automatic scan.
REQ-011 ch_mask  input  N  scan-mode channel enables; bit i=1 includes channel i.
REQ-012 dout  output  W  registered selected data.
REQ-013 ch_out  output  SW  registered index of the channel currently presented on dout.
REQ-014 valid  output  1  registered; 1 when dout/ch_out hold a live sample.
REQ-015 wrap  output  1  one-cycle pulse when a scan sweep wraps from a higher to a lower-or-equal index.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, MANUAL and SCAN.
REQ-017 Transitions: en=0 -> IDLE; en=1 & mode=0 -> MANUAL; en=1 & mode=1 -> SCAN; all evaluated every cycle, with en taking priority.
REQ-018 IDLE: valid=0, wrap=0; dout and ch_out hold their last values; dwell counter cleared.
REQ-019 MANUAL: each cycle dout <= din[sel*W +: W], ch_out <= sel, valid <= 1; latency is 1 clock from sel/din to outputs.
REQ-020 Entry into SCAN from any state SHALL select the lowest-indexed channel with ch_mask=1 and clear the dwell counter.
REQ-021 SCAN: dout <= data of the current channel every cycle, not only at channel change, so dout tracks din with 1-cycle latency.
REQ-022 SCAN: the dwell counter (width $clog2(DWELL+1)) increments every cycle; when it reaches DWELL-1, the next cycle moves to the next channel with ch_mask=1 in circular increasing order, and the counter clears.
REQ-023 wrap SHALL pulse in the same cycle that ch_out takes an index less than or equal to the previous index due to an advance.
REQ-024 Single enabled channel: ch_out stays constant; wrap pulses at every dwell expiry.
REQ-025 ch_mask all zero in SCAN: valid=0, wrap=0, ch_out holds, counter held at 0; scan resumes at the lowest set bit once any bit is set.
REQ-026 If the current channel's mask bit is cleared mid-dwell, the block SHALL advance on the next edge regardless of the counter, applying the REQ-023 wrap rule.
REQ-027 MANUAL to SCAN to MANUAL switching SHALL NOT produce a gap: valid stays 1 if the new state has a live sample.
REQ-028 All outputs SHALL be driven from registers; there is no combinational path from input to output.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, dout=0, ch_out=0, valid=0, wrap=0, dwell counter=0.
REQ-030 rst takes priority over en, mode and all other inputs; reset mid-scan abandons the sweep, and the next SCAN entry restarts per REQ-020.

Verification
REQ-031 N=8, W=4, manual mode, sel stepped 0..7 with din channel i = i+3 -> one cycle later dout=i+3, ch_out=i, valid=1.
REQ-032 Scan, DWELL=4, ch_mask=8'b1010_0101 -> ch_out sequence 0,2,5,7,0, each held 4 cycles; wrap=1 only in the first cycle of the return to 0.
REQ-033 Scan, ch_mask=8'b0001_0000 -> ch_out=4 constant; wrap pulses every 4 cycles.
REQ-034 Scan on channel 2, ch_mask bit 2 cleared at dwell count 1 (mask 0xA1) -> next edge ch_out=5, counter=0.
REQ-035 Scan, ch_mask=0 -> valid=0 the next cycle; then set ch_mask=8'h40 -> ch_out=6, valid=1 the next cycle.
REQ-036 rst=1 asserted mid-scan, with en=1 and mode=1 held -> outputs all 0 and valid=0; after release, ch_out starts at the lowest set mask bit.
